// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared opcode constants and FSM state encoding
package alu_arbiter_pkg;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: combinational 32-bit integer ALU with zero and carry/borrow flags
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [2:0]  opcode,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        z,
  output logic        c
);
  logic [32:0] sum;
  logic signed [31:0] sra;
  // select the result; sub doubles as the arithmetic-shift select for srl
  always_comb begin
    sum = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    sra = $signed(a) >>> b[4:0];
    case (opcode)
      OP_ADD:  y = sum[31:0];
      OP_SLL:  y = a << b[4:0];
      OP_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: y = {31'd0, a < b};
      OP_XOR:  y = a ^ b;
      OP_SRL:  y = sub ? sra : a >> b[4:0];
      OP_OR:   y = a | b;
      default: y = a & b;
    endcase
    z = y == 32'd0;
    c = sum[32];
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two valid/ready requesters
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter logic RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [2:0]  req_opcode_0,
  input  logic [2:0]  req_opcode_1,
  input  logic        req_sub_0,
  input  logic        req_sub_1,
  input  logic [31:0] req_op1_0,
  input  logic [31:0] req_op1_1,
  input  logic [31:0] req_op2_0,
  input  logic [31:0] req_op2_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_0,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_data_0,
  output logic [31:0] rsp_data_1,
  output logic        rsp_z_0,
  output logic        rsp_z_1,
  output logic        rsp_c_0,
  output logic        rsp_c_1,
  output logic        busy
);
  state_t state, nxt;
  logic gid, acc, hs, owner, last;
  logic [2:0] op_code;
  logic op_sub;
  logic [31:0] op_a, op_b, alu_y, data_r;
  logic alu_z, alu_c, z_r, c_r;

  alu u_alu (
    .opcode(op_code),
    .sub(op_sub),
    .a(op_a),
    .b(op_b),
    .y(alu_y),
    .z(alu_z),
    .c(alu_c)
  );

  // state register; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;

  // next state: accept, one evaluate cycle, hold until the owner consumes
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (acc) nxt = EXEC;
      EXEC:    nxt = RESP;
      RESP:    if (hs) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // grant, handshakes and status; ties go to the requester that did not win last
  always_comb begin
    gid = (req_valid_0 && req_valid_1) ? (RR_EN ? ~last : 1'b0) : req_valid_1;
    req_ready_0 = (state == IDLE) && req_valid_0 && !gid;
    req_ready_1 = (state == IDLE) && req_valid_1 && gid;
    acc = req_ready_0 || req_ready_1;
    hs = (state == RESP) && (owner ? rsp_ready_1 : rsp_ready_0);
    rsp_valid_0 = (state == RESP) && !owner;
    rsp_valid_1 = (state == RESP) && owner;
    busy = state != IDLE;
  end

  // operand latch on acceptance, result capture at the end of EXEC
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_code <= OP_ADD;
      op_sub <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      owner <= 1'b0;
      last <= 1'b1;
      data_r <= '0;
      z_r <= 1'b0;
      c_r <= 1'b0;
    end else begin
      if (acc) begin
        op_code <= gid ? req_opcode_1 : req_opcode_0;
        op_sub <= gid ? req_sub_1 : req_sub_0;
        op_a <= gid ? req_op1_1 : req_op1_0;
        op_b <= gid ? req_op2_1 : req_op2_0;
        owner <= gid;
        last <= gid;
      end
      if (state == EXEC) begin
        data_r <= alu_y;
        z_r <= alu_z;
        c_r <= alu_c && (op_code == OP_ADD);
      end
    end

  assign rsp_data_0 = data_r;
  assign rsp_data_1 = data_r;
  assign rsp_z_0 = z_r;
  assign rsp_z_1 = z_r;
  assign rsp_c_0 = c_r;
  assign rsp_c_1 = c_r;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks against a transaction-level model
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic req_valid_0, req_valid_1, req_sub_0, req_sub_1, rsp_ready_0, rsp_ready_1;
  logic [2:0] req_opcode_0, req_opcode_1;
  logic [31:0] req_op1_0, req_op1_1, req_op2_0, req_op2_1;
  logic req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
  logic [31:0] rsp_data_0, rsp_data_1;
  logic rsp_z_0, rsp_z_1, rsp_c_0, rsp_c_1, busy;
  logic fp_req_ready_0, fp_req_ready_1, fp_rsp_valid_0, fp_rsp_valid_1;
  logic [31:0] fp_rsp_data_0, fp_rsp_data_1;
  logic fp_rsp_z_0, fp_rsp_z_1, fp_rsp_c_0, fp_rsp_c_1, fp_busy;
  int n_tests = 0, n_fail = 0;
  bit pend = 0, acc = 0, fp_on = 0;
  int age = 0, m_id = 0, m_last = 1, acc_id = 0, n_acc = 0, fp_cnt = 0;
  logic [32:0] m_exp;
  logic [31:0] last_data;
  logic last_z, last_c;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_opcode_0(req_opcode_0), .req_opcode_1(req_opcode_1),
    .req_sub_0(req_sub_0), .req_sub_1(req_sub_1),
    .req_op1_0(req_op1_0), .req_op1_1(req_op1_1),
    .req_op2_0(req_op2_0), .req_op2_1(req_op2_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1),
    .rsp_z_0(rsp_z_0), .rsp_z_1(rsp_z_1),
    .rsp_c_0(rsp_c_0), .rsp_c_1(rsp_c_1),
    .busy(busy)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(fp_req_ready_0), .req_ready_1(fp_req_ready_1),
    .req_opcode_0(req_opcode_0), .req_opcode_1(req_opcode_1),
    .req_sub_0(req_sub_0), .req_sub_1(req_sub_1),
    .req_op1_0(req_op1_0), .req_op1_1(req_op1_1),
    .req_op2_0(req_op2_0), .req_op2_1(req_op2_1),
    .rsp_valid_0(fp_rsp_valid_0), .rsp_valid_1(fp_rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_data_0(fp_rsp_data_0), .rsp_data_1(fp_rsp_data_1),
    .rsp_z_0(fp_rsp_z_0), .rsp_z_1(fp_rsp_z_1),
    .rsp_c_0(fp_rsp_c_0), .rsp_c_1(fp_rsp_c_1),
    .busy(fp_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference result {carry, value} from the instruction-set meaning of each opcode
  function automatic logic [32:0] ref_alu(input logic [2:0] o, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic c;
    int sh;
    sh = int'(b[4:0]);
    c = 1'b0;
    case (o)
      3'd0: begin
        r = s ? a - b : a + b;
        c = s ? (a < b) : ((longint'(a) + longint'(b)) > 64'hFFFFFFFF);
      end
      3'd1: r = a << sh;
      3'd2: r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        r = a >> sh;
        if (s && a[31]) r = r | ~(32'hFFFFFFFF >> sh);
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return {c, r};
  endfunction

  // one clock: check against the model at negedge, advance the model at posedge
  task automatic cyc();
    bit vis, hs, take;
    int g;
    logic [32:0] e;
    @(negedge clk);
    vis = pend && age >= 1;
    chk("rsp_valid_0", rsp_valid_0, vis && m_id == 0);
    chk("rsp_valid_1", rsp_valid_1, vis && m_id == 1);
    chk("busy", busy, pend);
    if (vis) begin
      chk("rsp_data", m_id ? rsp_data_1 : rsp_data_0, m_exp[31:0]);
      chk("rsp_z", m_id ? rsp_z_1 : rsp_z_0, m_exp[31:0] == 32'd0);
      chk("rsp_c", m_id ? rsp_c_1 : rsp_c_0, m_exp[32]);
    end
    g = (req_valid_0 && req_valid_1) ? (m_last == 1 ? 0 : 1) : (req_valid_1 ? 1 : 0);
    take = !pend && (req_valid_0 || req_valid_1);
    chk("req_ready_0", req_ready_0, take && g == 0);
    chk("req_ready_1", req_ready_1, take && g == 1);
    if (fp_on) begin
      chk("fp_req_ready_1", fp_req_ready_1, 0);
      chk("fp_rsp_valid_1", fp_rsp_valid_1, 0);
      fp_cnt += int'(fp_req_ready_0);
    end
    hs = vis && (m_id ? rsp_ready_1 : rsp_ready_0);
    if (hs) begin
      last_data = m_id ? rsp_data_1 : rsp_data_0;
      last_z = m_id ? rsp_z_1 : rsp_z_0;
      last_c = m_id ? rsp_c_1 : rsp_c_0;
    end
    e = g ? ref_alu(req_opcode_1, req_sub_1, req_op1_1, req_op2_1)
          : ref_alu(req_opcode_0, req_sub_0, req_op1_0, req_op2_0);
    @(posedge clk);
    acc = take;
    acc_id = g;
    if (take) begin
      pend = 1;
      age = 0;
      m_id = g;
      m_last = g;
      m_exp = e;
      n_acc++;
    end else if (hs) pend = 0;
    else if (pend) age++;
    #1;
  endtask

  task automatic set_req(input int id, input logic [2:0] o, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin
      req_valid_0 = 1; req_opcode_0 = o; req_sub_0 = s; req_op1_0 = a; req_op2_0 = b;
    end else begin
      req_valid_1 = 1; req_opcode_1 = o; req_sub_1 = s; req_op1_1 = a; req_op2_1 = b;
    end
  endtask

  task automatic issue(input int id, input logic [2:0] o, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 0;
    set_req(id, o, s, a, b);
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc();
      ok = acc && acc_id == id;
    end
    chk("issue_accepted", ok, 1);
    if (id == 0) req_valid_0 = 0;
    else req_valid_1 = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && pend; i++) cyc();
    chk("drain_done", pend, 0);
  endtask

  task automatic rand_port(input int id);
    logic [31:0] a, b;
    a = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(15, 0)) : $urandom;
    b = ($urandom_range(3, 0) == 0) ? a : $urandom;
    if ($urandom_range(1, 0) == 1) set_req(id, 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), a, b);
    else if (id == 0) req_valid_0 = 0;
    else req_valid_1 = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    pend = 0;
    m_last = 1;
    #1;
    chk("rst_req_ready_0", req_ready_0, 0);
    chk("rst_req_ready_1", req_ready_1, 0);
    chk("rst_rsp_valid", {rsp_valid_1, rsp_valid_0}, 0);
    chk("rst_rsp_data", rsp_data_0 | rsp_data_1, 0);
    chk("rst_flags", {rsp_z_0, rsp_z_1, rsp_c_0, rsp_c_1}, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    {req_valid_0, req_valid_1, req_sub_0, req_sub_1} = '0;
    {req_opcode_0, req_opcode_1} = '0;
    {req_op1_0, req_op1_1, req_op2_0, req_op2_1} = '0;
    rsp_ready_0 = 1;
    rsp_ready_1 = 1;
    do_reset();
    issue(0, OP_ADD, 0, 32'd5, 32'd3);
    drain();
    chk("add_data", last_data, 32'h8);
    chk("add_zc", {last_z, last_c}, 0);
    issue(1, OP_ADD, 1, 32'd3, 32'd5);
    drain();
    chk("sub_data", last_data, 32'hFFFFFFFE);
    chk("sub_borrow", last_c, 1);
    issue(1, OP_XOR, 0, 32'd7, 32'd7);
    drain();
    chk("xor_data", last_data, 0);
    chk("xor_zc", {last_z, last_c}, 2'b10);
    issue(0, OP_SRL, 1, 32'h80000000, 32'd4);
    drain();
    chk("sra_data", last_data, 32'hF8000000);
    issue(0, OP_SRL, 0, 32'h80000000, 32'd4);
    drain();
    chk("srl_data", last_data, 32'h08000000);
    rsp_ready_0 = 0;
    issue(0, OP_OR, 0, 32'h00F0, 32'h0F00);
    set_req(1, OP_SLT, 0, 32'hFFFFFFFF, 32'd1);
    repeat (6) cyc();
    rsp_ready_0 = 1;
    for (int i = 0; i < 10 && !(acc && acc_id == 1); i++) cyc();
    chk("bp_req1_accepted", acc && acc_id == 1, 1);
    req_valid_1 = 0;
    drain();
    chk("slt_data", last_data, 1);
    issue(0, OP_ADD, 0, 32'd1, 32'd2);
    do_reset();
    repeat (4) cyc();
    set_req(0, OP_SLTU, 0, 32'hFFFFFFFF, 32'd1);
    set_req(1, OP_AND, 0, 32'hFF, 32'h0F);
    cyc();
    chk("tie_after_reset", acc && acc_id == 0, 1);
    req_valid_0 = 0;
    for (int i = 0; i < 1500; i++) begin
      rsp_ready_0 = $urandom_range(3, 0) != 0;
      rsp_ready_1 = $urandom_range(3, 0) != 0;
      if (!req_valid_0 || (acc && acc_id == 0)) rand_port(0);
      else if ($urandom_range(15, 0) == 0) req_valid_0 = 0;
      if (!req_valid_1 || (acc && acc_id == 1)) rand_port(1);
      else if ($urandom_range(15, 0) == 0) req_valid_1 = 0;
      cyc();
    end
    {req_valid_0, req_valid_1} = '0;
    rsp_ready_0 = 1;
    rsp_ready_1 = 1;
    drain();
    do_reset();
    n_acc = 0;
    fp_on = 1;
    set_req(0, OP_ADD, 0, $urandom, $urandom);
    set_req(1, OP_XOR, 0, $urandom, $urandom);
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (acc) set_req(acc_id, 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), $urandom, $urandom);
    end
    fp_on = 0;
    chk("rr_grant_count", n_acc, 20);
    chk("fp_grant_count", fp_cnt, n_acc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares a single `alu` instance between two requesters, e.g. the integer execute stage and the address/CSR helper path. It accepts one operation at a time over a valid/ready request channel and latches the operands. It then runs them through the ALU and returns the registered result to the requester that issued it, over a valid/ready response channel. Arbitration is round-robin by default, or fixed priority.

## Interface
- `RR_EN`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, where requester 0 always wins.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset: asynchronous assert, active-low.
- `req_valid_0` / `req_valid_1`  in  1  request valid per requester.
- `req_ready_0` / `req_ready_1`  out  1  request accepted; high for the granted requester only.
- `req_opcode_0` / `req_opcode_1`  in  3  ALU opcode (000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and).
- `req_sub_0` / `req_sub_1`  in  1  sub select for 000; arithmetic shift select for 101.
- `req_op1_0` / `req_op1_1`, `req_op2_0` / `req_op2_1`  in  32  operands.
- `rsp_valid_0` / `rsp_valid_1`  out  1  result valid for that requester.
- `rsp_ready_0` / `rsp_ready_1`  in  1  requester consumes the result.
- `rsp_data_0` / `rsp_data_1`  out  32  ALU result.
- `rsp_z_0` / `rsp_z_1`  out  1  result-is-zero flag.
- `rsp_c_0` / `rsp_c_1`  out  1  carry/borrow; meaningful for opcode 000, forced 0 otherwise.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant is combinational from `req_valid_*` and the priority pointer.
  - `req_ready_g` is high only for the granted requester.
  - On `req_valid_g & req_ready_g`:
    - latch opcode, sub, op1 and op2 into the operand registers;
    - record the granted id;
    - go to EXEC.
- **EXEC**
  - The ALU evaluates the latched operands combinationally.
  - At the clock edge, capture `alu_out`, `z`, and `c` (c gated by opcode==000) into the response registers.
  - Go to RESP.
- **RESP**
  - `rsp_valid` is high for the recorded id only.
  - Data and flags are held stable until `rsp_ready` for that id.
  - On handshake, go to IDLE.
  - `rsp_ready` of the non-owning requester is ignored.
- **Arbitration**
  - Round-robin: pointer `last` holds the id of the last accepted request.
  - When both requesters are valid, the one ≠ `last` wins.
  - `last` updates only on request acceptance.
  - Fixed priority (`RR_EN`=0): requester 0 wins any tie; `last` is unused.
- **Requester obligations:** while `req_valid` is high and not yet accepted, `req_*` fields must stay stable. Dropping valid before acceptance is legal; the grant simply moves.
- **Width rules**
  - Add/sub is 33-bit: `{c,result} = op1 ± op2`.
  - Shift amount is `op2[4:0]`.
  - slt is signed and sltu is unsigned, both yielding 0 or 1.
- **Reset**
  - Asynchronous, any state. Goes to IDLE and discards any in-flight operation; no response is emitted for it.
  - `last` = 1, so requester 0 wins the first tie.

## Timing
- Reset values:
  - `req_ready_*` = 0, `rsp_valid_*` = 0, `rsp_data_*` = 0;
  - `rsp_z_*` = 0, `rsp_c_*` = 0, `busy` = 0.
- Latency: request accepted at edge T, then `rsp_valid` high in cycle T+2.
- Throughput: at most one operation per 3 cycles. `req_ready_*` is 0 in EXEC and RESP.
- Backpressure: RESP is held indefinitely while `rsp_ready` = 0, and no new request is accepted.
- `req_ready_*` depends combinationally on `req_valid_*` and state only, never on `rsp_ready_*`.
- Simultaneous valid on both ports in IDLE: exactly one `req_ready` is high in that cycle.

## Structure
- Shared package holds:
  - ALU opcode constants (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND);
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
- One sub-module: the existing `alu`, instantiated once and fed from the operand registers.
- Arbitration, the operand/response registers, and the FSM live in `alu_arbiter`.

## Test plan
- **Basic add:** req0 add 5+3 → `req_ready_0` in the same cycle; `rsp_valid_0` at T+2 with data 0x00000008, z=0, c=0.
- **Borrow:** req1 sub 3−5 → `rsp_data_1` 0xFFFFFFFE, c=1; then xor 7^7 → data 0, z=1, c=0.
- **Arithmetic shift:** opcode 101, sub=1, 0x80000000 by 4 → 0xF8000000; sub=0 → 0x08000000.
- **Contention:** both valid continuously from reset.
  - `RR_EN`=1 → grants alternate 0,1,0,1 with no extra cycles beyond 3 per op.
  - `RR_EN`=0 → requester 0 is granted every time.
- **Backpressure:** hold `rsp_ready_0` low for 5 cycles → data, flags, and `rsp_valid_0` are stable; `req_ready_1` stays 0 despite `req_valid_1`; req1 is accepted the cycle after the handshake.
- **Reset mid-EXEC:** assert `rst_n` low during EXEC → outputs go to reset values immediately; no `rsp_valid` follows; after release, a req0/req1 tie grants requester 0.
